// File: rtl/coeff_pkg.sv
// ---------------------------------------------------------------------------
// coeff_pkg
// Shared definitions for the coefficient capture path.
//   - Default coefficient geometry, shared with the quantizer and DCT stages
//     (float32 words, Y/Cb/Cr channels, 8x8 blocks).
//   - Channel / index field widths for the default geometry.
//   - Read FSM state encoding.
//   - ch_width(): channel-select width for an arbitrary channel count.
// ---------------------------------------------------------------------------
package coeff_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CH_DEF     = 3;
    localparam int DEPTH_DEF  = 64;

    // A single-channel build still gets a 1-bit channel field.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    localparam int CH_W  = ch_width(CH_DEF);
    localparam int IDX_W = $clog2(DEPTH_DEF);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/coeff_bank_mem.sv
// ---------------------------------------------------------------------------
// coeff_bank_mem
// Two banks of CH x DEPTH coefficient registers.
//   clk          in   clock, rising edge
//   wr_en_i      in   write all CH words of one beat
//   wr_bank_i    in   bank written
//   wr_idx_i     in   coefficient index written
//   wr_data_i    in   CH*DATA_W beat, channel c at [c*DATA_W +: DATA_W]
//   rd_bank_i    in   bank read
//   rd_ch_i      in   channel read
//   rd_idx_i     in   coefficient index read
//   rd_data_o    out  combinational read word
// ---------------------------------------------------------------------------
module coeff_bank_mem
    import coeff_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int CH     = CH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CW     = ch_width(CH),
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic                 wr_bank_i,
    input  logic [IW-1:0]        wr_idx_i,
    input  logic [CH*DATA_W-1:0] wr_data_i,
    input  logic                 rd_bank_i,
    input  logic [CW-1:0]        rd_ch_i,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [DATA_W-1:0]    rd_data_o
);

    logic [DATA_W-1:0] mem_q [2][CH][DEPTH];

    // NOTE: the data array has no reset; bank_full flags in the parent decide
    // what is valid, so resetting storage would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int c = 0; c < CH; c++) begin
                mem_q[wr_bank_i][c][wr_idx_i] <= wr_data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_ch_i][rd_idx_i];

endmodule

// File: rtl/coeff_capture_buffer.sv
// ---------------------------------------------------------------------------
// coeff_capture_buffer
// Ping-pong capture buffer: CH coefficients per input beat, DEPTH beats per
// block; a full bank is streamed out serially, channel-major, while the
// other bank fills.
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   in_valid     in   input beat present
//   in_data      in   CH*DATA_W beat, channel c at [c*DATA_W +: DATA_W]
//   in_ready     out  write bank can accept a beat
//   out_valid    out  out_data valid
//   out_data     out  current coefficient
//   out_ch       out  channel of out_data
//   out_idx      out  coefficient index of out_data
//   out_last     out  final word of the block
//   out_ready    in   consumer accepts the word
//   overflow     out  sticky: a beat was dropped
//   clear_ovf    in   synchronous overflow clear (a coincident drop wins)
//   blocks_done  out  count of fully drained blocks, wrapping
// ---------------------------------------------------------------------------
module coeff_capture_buffer
    import coeff_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int CH     = CH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int CNT_W  = 16,
    localparam int CW     = ch_width(CH),
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [CW-1:0]        out_ch,
    output logic [IW-1:0]        out_idx,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 overflow,
    input  logic                 clear_ovf,
    output logic [CNT_W-1:0]     blocks_done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CH - 1);

    // in_ready is held low until the first edge after reset release.
    logic             active_q;
    logic             wr_bank_q,     wr_bank_d;
    logic [IW-1:0]    wr_idx_q,      wr_idx_d;
    logic [1:0]       bank_full_q,   bank_full_d;
    logic             rd_bank_q,     rd_bank_d;
    logic [0:0]       state_q,       state_d;
    logic [CW-1:0]    rd_ch_q,       rd_ch_d;
    logic [IW-1:0]    rd_idx_q,      rd_idx_d;
    logic             overflow_q,    overflow_d;
    logic [CNT_W-1:0] blocks_done_q, blocks_done_d;

    logic              accept;
    logic              drop;
    logic              sending;
    logic              at_last;
    logic [DATA_W-1:0] rd_data;

    assign in_ready = active_q && !bank_full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;
    assign sending  = (state_q == ST_SEND);
    assign at_last  = (rd_ch_q == LAST_CH) && (rd_idx_q == LAST_IDX);

    coeff_bank_mem #(
        .DATA_W (DATA_W),
        .CH     (CH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_bank_i (wr_bank_q),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (in_data),
        .rd_bank_i (rd_bank_q),
        .rd_ch_i   (rd_ch_q),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (rd_data)
    );

    // NOTE: every next-state signal takes its current value first, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        wr_bank_d     = wr_bank_q;
        wr_idx_d      = wr_idx_q;
        bank_full_d   = bank_full_q;
        rd_bank_d     = rd_bank_q;
        state_d       = state_q;
        rd_ch_d       = rd_ch_q;
        rd_idx_d      = rd_idx_q;
        overflow_d    = overflow_q;
        blocks_done_d = blocks_done_q;

        // Write side. The read bank is always full, so wr_bank differs from
        // rd_bank whenever both sides touch bank_full on the same edge.
        if (accept) begin
            if (wr_idx_q == LAST_IDX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
                wr_idx_d               = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end

        // Drop is checked last so it wins over a coincident clear.
        if (clear_ovf) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;

        // Read FSM.
        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = ST_SEND;
                    rd_ch_d  = '0;
                    rd_idx_d = '0;
                end
            end
            default: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        if (at_last) begin
                            bank_full_d[rd_bank_q] = 1'b0;
                            rd_bank_d              = !rd_bank_q;
                            blocks_done_d          = blocks_done_q + CNT_W'(1);
                            rd_ch_d                = '0;
                            state_d                = ST_IDLE;
                        end else begin
                            rd_ch_d = rd_ch_q + CW'(1);
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q      <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            bank_full_q   <= '0;
            rd_bank_q     <= 1'b0;
            state_q       <= ST_IDLE;
            rd_ch_q       <= '0;
            rd_idx_q      <= '0;
            overflow_q    <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            active_q      <= 1'b1;
            wr_bank_q     <= wr_bank_d;
            wr_idx_q      <= wr_idx_d;
            bank_full_q   <= bank_full_d;
            rd_bank_q     <= rd_bank_d;
            state_q       <= state_d;
            rd_ch_q       <= rd_ch_d;
            rd_idx_q      <= rd_idx_d;
            overflow_q    <= overflow_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    // Output fields are forced to zero outside SEND; inside SEND they come
    // straight from held registers, so they stay stable under backpressure.
    assign out_valid   = sending;
    assign out_data    = sending ? rd_data  : '0;
    assign out_ch      = sending ? rd_ch_q  : '0;
    assign out_idx     = sending ? rd_idx_q : '0;
    assign out_last    = sending && at_last;
    assign overflow    = overflow_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: doc/coeff_capture_buffer.md
Name: coeff_capture_buffer

Overview:
Parametrised ping-pong capture buffer for per-block transform coefficients, such as float32 Y/Cb/Cr DCT or quantizer outputs, produced by image_compression_ip. It accepts CH channels in parallel, one coefficient per channel per beat. A full block of DEPTH beats is held in one bank and streamed out serially, channel-major, over a valid/ready port. This lets an on-chip consumer or debug path drain results without stalling the pipeline, while the other bank fills.

Parameters:
DATA_W, 32, width of one coefficient word (IEEE-754 single by default; the contents are opaque to this block).
CH, 3, number of parallel channels (Y, Cb, Cr).
DEPTH, 64, coefficients per channel per block (8x8).
CNT_W, 16, width of the blocks_done counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  input beat present.
in_data  in  CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
in_ready  out  1  the write bank can accept a beat.
out_valid  out  1  out_data is valid.
out_data  out  DATA_W  current coefficient.
out_ch  out  max(1,$clog2(CH))  channel of out_data.
out_idx  out  $clog2(DEPTH)  coefficient index of out_data.
out_last  out  1  final word of the block.
out_ready  in  1  consumer accepts the word.
overflow  out  1  sticky; a beat was dropped.
clear_ovf  in  1  synchronous clear of overflow.
blocks_done  out  CNT_W  count of fully drained blocks; wraps.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst=0:
  - in_ready=0; out_valid=0, out_data=0, out_ch=0, out_idx=0, out_last=0; overflow=0; blocks_done=0.
  - Both banks are marked empty; wr_bank=0, rd_bank=0; read FSM in IDLE.
  - Partial block data is discarded.
  - First cycle after release: in_ready=1.
- Storage: 2 x CH x DEPTH register array with combinational read mux. bank_full[1:0] flags.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - Accept when in_valid && in_ready: write all CH words at wr_idx; wr_idx++.
  - On accepting wr_idx==DEPTH-1: set bank_full[wr_bank], toggle wr_bank, wr_idx=0.
  - in_valid && !in_ready: beat dropped, overflow<=1 the same edge.
  - overflow holds until clear_ovf=1. If set and clear coincide, set wins.
- Read FSM:
  - IDLE: if bank_full[rd_bank], go to SEND with rd_ch=0, rd_idx=0.
  - SEND: out_valid=1, out_data=mem[rd_bank][rd_ch][rd_idx], out_ch=rd_ch, out_idx=rd_idx, out_last=(rd_ch==CH-1 && rd_idx==DEPTH-1).
  - Handshake out_valid && out_ready: advance rd_idx; at DEPTH-1 wrap to 0 and increment rd_ch.
  - On the out_last handshake: clear bank_full[rd_bank], toggle rd_bank, blocks_done++ (wraps at 2^CNT_W), go to IDLE.
  - Outside SEND, out_data/out_ch/out_idx/out_last are 0.
- Latency and throughput:
  - Last input beat accepted at edge k: out_valid=1 from edge k+1.
  - One word per cycle while out_ready=1.
  - Exactly one idle cycle (out_valid=0) between consecutive blocks.
- Backpressure: while out_valid && !out_ready, out_data, out_ch, out_idx and out_last are held stable.
- Simultaneous events:
  - A read-bank release and a write-bank fill on the same edge update independent flags.
  - in_ready for the released bank rises the cycle after release.
  - The bank being read is never written, because it is full.
- Ordering: blocks are drained strictly in fill order.

Decomposition:
- Shared package (e.g. coeff_pkg) holds:
  - localparams CH_W=max(1,$clog2(CH)) and IDX_W=$clog2(DEPTH);
  - read FSM state encoding IDLE=1'b0, SEND=1'b1;
  - the default DATA_W/CH/DEPTH values shared with the quantizer and DCT stages.
- One natural sub-module: coeff_bank_mem. It holds the 2xCHxDEPTH register array, takes a CH-wide write port and a single-word combinational read port, and has no reset on data.

Test Plan:
- Reset: rst=0 then 1. Expect in_ready=1 next cycle; out_valid=0; overflow=0; blocks_done=0.
- Single block, CH=3, DEPTH=64, out_ready=1. Drive in_data ch c, beat i = {c[7:0],i[23:0]}.
  - Expect 192 words in order ch0 idx0..63, then ch1, then ch2.
  - out_valid first high one edge after the beat-63 edge; out_last only on {2,63}.
  - blocks_done=1 afterwards; then one out_valid=0 cycle.
- Overflow, out_ready=0: stream 129 beats. Expect in_ready=0 after beat 128; overflow=1 after beat 129.
  - Drain with out_ready=1: blocks 1 and 2 come out intact.
  - Pulse clear_ovf: overflow=0.
- Backpressure: out_ready toggles with pattern 1,0,0,1 during a drain. Expect outputs stable during low cycles, no duplicates, no gaps, all 192 words received.
- Reset mid-drain: rst=0 at word 50. Expect out_valid=0 and blocks_done=0 immediately.
  - A new block after release starts at ch0 idx0 with the new data.
- Simultaneous release and fill: time the bank-1 fill edge to coincide with the bank-0 out_last handshake.
  - Expect both flags correct, in_ready=1 next cycle, and bank 1 drained after exactly one idle cycle.
